my_ddr3_rd_check: RTL and testbench
===================================

Name: my_ddr3_rd_check

Overview:
- Read-side consumer and checker for the DDR3-as-FIFO path. It is the counterpart of the data generator that fills the FIFO.
- Sits between my_ddr3_drive's read port (rd_data/rd_vld/empty) and the debug ILA.
- Issues read requests while data is available and bounds the number of in-flight reads.
- Compares each returned 256-bit word against the expected incrementing pattern. Reports word count, error count, first failing index and a read-latency timeout.

Parameters:
- DATA_W, 256, width of rd_data; must be a multiple of 32.
- SEQ_W, 32, width of the sequence number replicated across each word.
- MAX_OUTSTANDING, 4, maximum reads requested but not yet returned (1..15).
- TIMEOUT_CYC, 4096, cycles without rd_vld while reads are outstanding before a timeout is declared.

Ports:
- ui_clk  in  1  MIG user-interface clock; sole clock.
- rst  in  1  synchronous, active-high reset.
- chk_en  in  1  level; 1 = issue reads and check.
- empty  in  1  drive FIFO empty flag.
- rd_req  out  1  one-cycle read request to the drive.
- rd_data  in  DATA_W  returned read word.
- rd_vld  in  1  rd_data valid, one cycle per word.
- word_cnt  out  32  number of words received (wraps).
- err_cnt  out  16  number of mismatching words (saturates at 16'hFFFF).
- err_flag  out  1  sticky; at least one mismatch or spurious word.
- first_err_idx  out  32  word_cnt value of the first mismatch.
- timeout  out  1  sticky; read-latency timeout.
- busy  out  1  1 when state is RUN or DRAIN.

Behaviour:
- Reset (rst=1 at an ui_clk edge) clears everything:
  - All outputs, the outstanding counter, the expected sequence number exp_seq, the timeout counter, and first_err_idx are set to 0.
  - State goes to IDLE.
  - Reset mid-operation discards in-flight reads; the drive shares rst.
- Expected word k is {DATA_W/SEQ_W{k[SEQ_W-1:0]}}, with exp_seq starting at 0.
- States:
  - IDLE -> RUN when chk_en=1.
  - RUN -> DRAIN when chk_en=0 and outstanding>0.
  - RUN -> IDLE when chk_en=0 and outstanding=0.
  - DRAIN -> IDLE when outstanding=0.
  - DRAIN -> RUN if chk_en returns to 1.
  - Any state -> FAIL on timeout. FAIL is left only by rst.
- rd_req is high for one cycle only in RUN, when empty=0 and outstanding<MAX_OUTSTANDING, and is registered.
  - Back-to-back requests are allowed.
  - No requests are issued in IDLE, DRAIN or FAIL.
- Outstanding counter:
  - +1 on rd_req, -1 on rd_vld, unchanged when both occur in the same cycle.
  - rd_vld with outstanding=0 is spurious: the counter stays 0, err_flag is set and err_cnt is incremented; the word is still consumed.
- On rd_vld:
  - rd_data is registered with exp_seq.
  - exp_seq and word_cnt increment at that same edge.
  - The compare result is applied one cycle later: err_cnt increments and err_flag is set on any 32-bit lane mismatch.
  - err_cnt and err_flag therefore lag rd_vld by exactly 1 cycle.
- first_err_idx captures the index of the first mismatching word. It is written only while err_flag=0; a spurious-only error does not write it.
- Timeout counter:
  - Counts cycles with outstanding>0 and rd_vld=0.
  - Cleared on rd_vld or when outstanding=0.
  - Reaching TIMEOUT_CYC-1 sets timeout=1 and enters FAIL.
  - rd_vld in FAIL is ignored.
- Wrap-around: exp_seq and word_cnt wrap modulo 2^SEQ_W and 2^32 with no error raised; the generator wraps identically.
- Leaving RUN does not reset exp_seq; re-enable resumes the sequence.

Decomposition:
- Package my_ddr3_pkg holds:
  - DATA_W, SEQ_W;
  - the state encoding (IDLE/RUN/DRAIN/FAIL);
  - the pattern function seq->word, shared with the generator.
- One sub-module, my_ddr3_exp_gen: holds exp_seq, produces the expected word, and advances on a step input.

Test Plan:
- 16 words k=0..15 pre-loaded, chk_en=1, drive latency 20 cycles -> 16 rd_req, outstanding never >4, word_cnt=16, err_cnt=0, err_flag=0.
- Word 5 lane 3 corrupted to 32'hDEADBEEF -> err_cnt=1 one cycle after the 6th rd_vld, err_flag=1, first_err_idx=5; a later corrupt word 9 leaves first_err_idx=5, err_cnt=2.
- Drive never answers after 2 requests, TIMEOUT_CYC=64 -> timeout=1 at the 64th idle cycle, state FAIL, no further rd_req, rst clears all.
- chk_en dropped with 3 outstanding -> no new rd_req, busy=1 until the 3rd rd_vld, then IDLE; re-enable continues at the next sequence number with err_cnt=0.
- rd_vld pulse with outstanding=0 -> err_cnt=1, err_flag=1, first_err_idx unchanged (0), outstanding stays 0.
- rd_req and rd_vld in the same cycle with outstanding=4 -> outstanding stays 4 and no rd_req is issued until the count drops below 4.

Source files
------------

// File: rtl/my_ddr3_pkg.sv
// Shared definitions for the DDR3-as-FIFO data path: word geometry, checker
// state encoding and the sequence-number-to-word pattern used by both ends.
package my_ddr3_pkg;

    localparam int DATA_W = 256;
    localparam int SEQ_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FAIL  = 2'd3
    } state_t;

    function automatic logic [DATA_W-1:0] pattern(input logic [SEQ_W-1:0] seq);
        return {(DATA_W/SEQ_W){seq}};
    endfunction

endpackage

// File: rtl/my_ddr3_exp_gen.sv
// Expected-word generator: holds the running sequence number and presents the
// word the checker should see next; advances by one on each step.
module my_ddr3_exp_gen #(
    parameter int DATA_W = my_ddr3_pkg::DATA_W,
    parameter int SEQ_W  = my_ddr3_pkg::SEQ_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_step,
    output logic [DATA_W-1:0] o_word
);
    import my_ddr3_pkg::*;

    logic [SEQ_W-1:0] r_seq;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_seq <= '0;
        end else if (i_step) begin
            r_seq <= r_seq + 1'b1;
        end
    end

    // Reuse the generator's pattern function whenever the geometry matches it.
    if (DATA_W == my_ddr3_pkg::DATA_W && SEQ_W == my_ddr3_pkg::SEQ_W) begin : g_pkg_pattern
        assign o_word = pattern(r_seq);
    end else begin : g_local_pattern
        assign o_word = {(DATA_W/SEQ_W){r_seq}};
    end

endmodule

// File: rtl/my_ddr3_rd_check.sv
// Read-side consumer/checker for the DDR3 FIFO: paces read requests, bounds
// in-flight reads, checks returned words against the incrementing pattern.
module my_ddr3_rd_check #(
    parameter int DATA_W          = my_ddr3_pkg::DATA_W,
    parameter int SEQ_W           = my_ddr3_pkg::SEQ_W,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYC     = 4096
) (
    input  logic              ui_clk,
    input  logic              rst,
    input  logic              chk_en,
    input  logic              empty,
    output logic              rd_req,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_vld,
    output logic [31:0]       word_cnt,
    output logic [15:0]       err_cnt,
    output logic              err_flag,
    output logic [31:0]       first_err_idx,
    output logic              timeout,
    output logic              busy
);
    import my_ddr3_pkg::*;

    localparam int OUT_W = 4;
    localparam int TO_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int LANES = DATA_W / 32;
    localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [OUT_W-1:0]  r_out;
    logic [OUT_W-1:0]  w_out_nxt;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_rd_req;
    logic              r_timeout;
    logic [31:0]       r_word_cnt;
    logic [15:0]       r_err_cnt;
    logic              r_err_flag;
    logic [31:0]       r_first_err_idx;

    logic              r_cmp_vld;
    logic              r_cmp_spur;
    logic [DATA_W-1:0] r_cmp_data;
    logic [DATA_W-1:0] r_cmp_exp;
    logic [31:0]       r_cmp_idx;

    logic              w_vld;
    logic              w_spur;
    logic              w_ret;
    logic              w_to_hit;
    logic [DATA_W-1:0] w_exp_word;
    logic [LANES-1:0]  w_lane_mis;
    logic              w_mis;
    logic              w_err;

    // Once failed, returned words are neither counted nor checked.
    assign w_vld  = rd_vld && (r_state != ST_FAIL);
    assign w_spur = w_vld && (r_out == '0);
    assign w_ret  = w_vld && (r_out != '0);

    assign w_to_hit = (r_state != ST_FAIL) && (r_out != '0) && !rd_vld
                      && (r_to_cnt == TO_LAST);

    always_comb begin
        w_out_nxt = r_out;
        if (r_rd_req && !w_ret) begin
            w_out_nxt = r_out + 1'b1;
        end else if (!r_rd_req && w_ret) begin
            w_out_nxt = r_out - 1'b1;
        end
    end

    always_ff @(posedge ui_clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Transitions look at the count as it will stand after this edge, so a
    // request already on the wire keeps the checker busy until it returns.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (chk_en) w_state_nxt = ST_RUN;
            ST_RUN:   if (!chk_en) w_state_nxt = (w_out_nxt != '0) ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: begin
                if (chk_en) begin
                    w_state_nxt = ST_RUN;
                end else if (w_out_nxt == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FAIL:  w_state_nxt = ST_FAIL;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (w_to_hit) begin
            w_state_nxt = ST_FAIL;
        end
    end

    always_ff @(posedge ui_clk) begin
        if (rst) begin
            r_out     <= '0;
            r_rd_req  <= 1'b0;
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_out    <= w_out_nxt;
            r_rd_req <= (w_state_nxt == ST_RUN) && !empty && (w_out_nxt < MAX_OUT);
            if ((r_out == '0) || rd_vld) begin
                r_to_cnt <= '0;
            end else if (r_state != ST_FAIL) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_to_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    my_ddr3_exp_gen #(
        .DATA_W (DATA_W),
        .SEQ_W  (SEQ_W)
    ) u_exp_gen (
        .i_clk  (ui_clk),
        .i_rst  (rst),
        .i_step (w_vld),
        .o_word (w_exp_word)
    );

    always_ff @(posedge ui_clk) begin
        if (rst) begin
            r_cmp_vld  <= 1'b0;
            r_cmp_spur <= 1'b0;
            r_cmp_data <= '0;
            r_cmp_exp  <= '0;
            r_cmp_idx  <= '0;
            r_word_cnt <= '0;
        end else begin
            r_cmp_vld <= w_vld;
            if (w_vld) begin
                r_cmp_spur <= w_spur;
                r_cmp_data <= rd_data;
                r_cmp_exp  <= w_exp_word;
                r_cmp_idx  <= r_word_cnt;
                r_word_cnt <= r_word_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_lane_mis = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_lane_mis[i] = (r_cmp_data[i*32 +: 32] != r_cmp_exp[i*32 +: 32]);
        end
    end

    assign w_mis = r_cmp_vld && (w_lane_mis != '0);
    assign w_err = w_mis || (r_cmp_vld && r_cmp_spur);

    always_ff @(posedge ui_clk) begin
        if (rst) begin
            r_err_cnt       <= '0;
            r_err_flag      <= 1'b0;
            r_first_err_idx <= '0;
        end else begin
            if (w_err && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
            if (w_err) begin
                r_err_flag <= 1'b1;
            end
            if (w_mis && !r_err_flag) begin
                r_first_err_idx <= r_cmp_idx;
            end
        end
    end

    assign rd_req        = r_rd_req;
    assign word_cnt      = r_word_cnt;
    assign err_cnt       = r_err_cnt;
    assign err_flag      = r_err_flag;
    assign first_err_idx = r_first_err_idx;
    assign timeout       = r_timeout;
    assign busy          = (r_state == ST_RUN) || (r_state == ST_DRAIN);

endmodule

// File: tb/tb_my_ddr3_rd_check.sv
// Directed bench for my_ddr3_rd_check: a behavioural drive model answers read
// requests after a fixed latency while directed scenarios check the results.
module tb_my_ddr3_rd_check;

    logic         ui_clk = 1'b0;
    logic         rst = 1'b1;
    logic         chk_en = 1'b0;
    logic         empty = 1'b1;
    logic         rd_req;
    logic [255:0] rd_data = '0;
    logic         rd_vld = 1'b0;
    logic [31:0]  word_cnt;
    logic [15:0]  err_cnt;
    logic         err_flag;
    logic [31:0]  first_err_idx;
    logic         timeout;
    logic         busy;

    int checks = 0;
    int failures = 0;

    // drive model state
    int          avail = 0;
    int          lat = 20;
    bit          mute = 0;
    bit          spur_req = 0;
    logic [31:0] corrupt = '0;
    int          due[$];
    int          cyc = 0;
    int          reqs = 0;
    int          vlds = 0;
    int          bout = 0;
    int          max_out = 0;
    int          idle = 0;
    int          next_k = 0;

    my_ddr3_rd_check #(
        .TIMEOUT_CYC (64)
    ) dut (
        .ui_clk        (ui_clk),
        .rst           (rst),
        .chk_en        (chk_en),
        .empty         (empty),
        .rd_req        (rd_req),
        .rd_data       (rd_data),
        .rd_vld        (rd_vld),
        .word_cnt      (word_cnt),
        .err_cnt       (err_cnt),
        .err_flag      (err_flag),
        .first_err_idx (first_err_idx),
        .timeout       (timeout),
        .busy          (busy)
    );

    initial forever #5 ui_clk = ~ui_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] exp_word(input int k);
        logic [31:0] s;
        s = k[31:0];
        return {8{s}};
    endfunction

    // Drive model: acts mid-cycle, so its outputs are stable at each posedge.
    initial forever begin
        bit vld_now;
        @(negedge ui_clk);
        cyc++;
        vld_now = 0;
        if (spur_req) begin
            vld_now = 1;
            spur_req = 0;
        end else if (!mute && due.size() > 0 && due[0] <= cyc) begin
            void'(due.pop_front());
            vld_now = 1;
        end
        if (vld_now) begin
            rd_data = exp_word(next_k);
            if (next_k < 32 && corrupt[next_k]) rd_data[127:96] = 32'hDEADBEEF;
            next_k++;
            vlds++;
        end
        if (!timeout && bout > 0 && !vld_now) idle++;
        if (rd_req) begin
            reqs++;
            if (avail > 0) avail--;
            due.push_back(cyc + lat);
        end
        bout = bout + (rd_req ? 1 : 0) - ((vld_now && bout > 0) ? 1 : 0);
        if (bout > max_out) max_out = bout;
        rd_vld = vld_now;
        empty = (avail == 0);
    end

    task automatic tick();
        @(negedge ui_clk);
        #1;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        due.delete();
        avail = 0; lat = 20; mute = 0; spur_req = 0; corrupt = '0;
        reqs = 0; vlds = 0; bout = 0; max_out = 0; idle = 0; next_k = 0;
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_words(input string tag, input logic [31:0] n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (word_cnt == n) break;
            tick();
        end
        check_eq(tag, word_cnt, n);
    endtask

    initial begin
        int busy_low;
        int reqs_at;

        // reset state
        do_reset();
        check_eq("rst_rd_req", {31'd0, rd_req}, 32'd0);
        check_eq("rst_word_cnt", word_cnt, 32'd0);
        check_eq("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
        check_eq("rst_err_flag", {31'd0, err_flag}, 32'd0);
        check_eq("rst_first_idx", first_err_idx, 32'd0);
        check_eq("rst_timeout", {31'd0, timeout}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);

        // 16 clean words, latency 20
        avail = 16;
        chk_en = 1'b1;
        wait_words("clean_words", 32'd16, 400);
        repeat (3) tick();
        check_eq("clean_reqs", reqs, 16);
        check_eq("clean_max_out", max_out, 4);
        check_eq("clean_err_cnt", {16'd0, err_cnt}, 32'd0);
        check_eq("clean_err_flag", {31'd0, err_flag}, 32'd0);
        check_eq("clean_busy_run", {31'd0, busy}, 32'd1);
        chk_en = 1'b0;
        repeat (2) tick();
        check_eq("clean_busy_idle", {31'd0, busy}, 32'd0);

        // corrupt words 5 and 9, lane 3
        do_reset();
        avail = 16;
        corrupt = 32'h0000_0220;
        chk_en = 1'b1;
        wait_words("corr_word6", 32'd6, 400);
        check_eq("corr_lag", {16'd0, err_cnt}, 32'd0);
        tick();
        check_eq("corr_err_cnt1", {16'd0, err_cnt}, 32'd1);
        check_eq("corr_err_flag", {31'd0, err_flag}, 32'd1);
        check_eq("corr_first_idx", first_err_idx, 32'd5);
        wait_words("corr_words", 32'd16, 400);
        repeat (2) tick();
        check_eq("corr_err_cnt2", {16'd0, err_cnt}, 32'd2);
        check_eq("corr_first_keep", first_err_idx, 32'd5);

        // drive never answers after 2 requests
        do_reset();
        avail = 2;
        mute = 1;
        chk_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (timeout) break;
            tick();
        end
        check_eq("to_flag", {31'd0, timeout}, 32'd1);
        check_eq("to_idle_cycles", idle, 64);
        check_eq("to_reqs", reqs, 2);
        check_eq("to_busy", {31'd0, busy}, 32'd0);
        avail = 5;
        repeat (10) tick();
        check_eq("to_no_reqs", reqs, 2);
        do_reset();
        check_eq("to_rst_timeout", {31'd0, timeout}, 32'd0);
        check_eq("to_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("to_rst_words", word_cnt, 32'd0);

        // drop chk_en with 3 outstanding, then resume
        avail = 16;
        chk_en = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (reqs == 3) break;
            tick();
        end
        chk_en = 1'b0;
        reqs_at = reqs;
        busy_low = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!busy) busy_low++;
            if (vlds == 3) break;
        end
        check_eq("drain_reqs_at_drop", reqs_at, 3);
        check_eq("drain_busy_held", busy_low, 0);
        check_eq("drain_no_new_req", reqs, 3);
        repeat (2) tick();
        check_eq("drain_idle", {31'd0, busy}, 32'd0);
        check_eq("drain_words", word_cnt, 32'd3);
        chk_en = 1'b1;
        wait_words("resume_words", 32'd16, 400);
        repeat (2) tick();
        check_eq("resume_err_cnt", {16'd0, err_cnt}, 32'd0);

        // spurious rd_vld with nothing outstanding
        do_reset();
        spur_req = 1;
        repeat (4) tick();
        check_eq("spur_err_cnt", {16'd0, err_cnt}, 32'd1);
        check_eq("spur_err_flag", {31'd0, err_flag}, 32'd1);
        check_eq("spur_first_idx", first_err_idx, 32'd0);
        check_eq("spur_word_cnt", word_cnt, 32'd1);

        // outstanding cap holds across simultaneous request/return
        avail = 8;
        chk_en = 1'b1;
        wait_words("cap_words", 32'd9, 400);
        repeat (2) tick();
        check_eq("cap_reqs", reqs, 8);
        check_eq("cap_max_out", max_out, 4);
        check_eq("cap_err_cnt", {16'd0, err_cnt}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
